// File: rtl/divider_sequential.sv
// Sequential restoring unsigned divider: one quotient bit per clock over N cycles,
// with a start/busy/done handshake. Divide-by-zero short-circuits straight to DONE.
module divider_sequential #(
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);
    localparam int C = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         r_state;
    state_t         w_next;
    logic [C-1:0]   r_count;
    logic [N:0]     r_a;
    logic [N-1:0]   r_q;
    logic [N-1:0]   r_m;
    logic           r_dz;
    logic [N:0]     w_s;
    logic [N:0]     w_t;
    logic           w_accept;
    logic           w_zero;

    assign w_accept = start && (r_state != RUN);
    assign w_zero   = (divisor == '0);

    // Trial subtraction: a clear borrow bit means the divisor fits.
    assign w_s = {r_a[N-1:0], r_q[N-1]};
    assign w_t = w_s - {1'b0, r_m};

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (start) w_next = w_zero ? DONE : RUN;
                else       w_next = IDLE;
            end
            RUN: begin
                if (r_count == '0) w_next = DONE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
            r_a     <= '0;
            r_q     <= '0;
            r_m     <= '0;
            r_dz    <= 1'b0;
        end else if (w_accept) begin
            if (w_zero) begin
                r_q  <= '1;
                r_a  <= {1'b0, dividend};
                r_dz <= 1'b1;
            end else begin
                r_a     <= '0;
                r_q     <= dividend;
                r_m     <= divisor;
                r_count <= C'(N - 1);
                r_dz    <= 1'b0;
            end
        end else if (r_state == RUN) begin
            if (!w_t[N]) begin
                r_a <= w_t;
                r_q <= {r_q[N-2:0], 1'b1};
            end else begin
                r_a <= w_s;
                r_q <= {r_q[N-2:0], 1'b0};
            end
            if (r_count != '0) r_count <= r_count - 1'b1;
        end
    end

    assign busy        = (r_state == RUN);
    assign done        = (r_state == DONE);
    assign quotient    = r_q;
    assign remainder   = r_a[N-1:0];
    assign div_by_zero = r_dz;

endmodule

// File: tb/tb_divider_sequential.sv
// Self-checking bench for divider_sequential: directed handshake cases plus a
// shuffled sweep of all operand pairs, checked against a queued reference model.
module tb_divider_sequential;
    localparam int N = 4;

    logic         clock;
    logic         reset_n;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    typedef struct {
        logic [N-1:0] dd;
        logic [N-1:0] dv;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    divider_sequential #(.N(N)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drive a request and queue its reference result.
    task automatic issue(input logic [N-1:0] dd, input logic [N-1:0] dv);
        exp_t e;
        e.dd = dd;
        e.dv = dv;
        e.dz = (dv == '0);
        e.q  = e.dz ? {N{1'b1}} : N'(dd / dv);
        e.r  = e.dz ? dd : N'(dd % dv);
        sb.push_back(e);
        start    = 1'b1;
        dividend = dd;
        divisor  = dv;
    endtask

    // Wait for done, checking latency and busy-cycle count, then score the result.
    task automatic finish_op(input string tag, input int exp_lat, input int inject_at);
        int   lat;
        int   nbusy;
        logic d;
        exp_t e;
        lat   = 0;
        nbusy = 0;
        d     = 1'b0;
        while (!d && lat < 20) begin
            @(negedge clock);
            lat++;
            d = done;
            if (busy) nbusy++;
            if (lat == 1) begin
                start    = 1'b0;
                dividend = N'($urandom);
                divisor  = N'($urandom);
            end
            if (inject_at != 0 && lat == inject_at) begin
                start    = 1'b1;
                dividend = 4'd6;
                divisor  = 4'd2;
            end
            if (inject_at != 0 && lat == inject_at + 1) start = 1'b0;
        end
        chk({tag, " done_seen"}, d, 1'b1);
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " busy_cycles"}, nbusy, exp_lat - 1);
        if (sb.size() == 0) begin
            chk({tag, " scoreboard_nonempty"}, sb.size(), 1);
        end else begin
            e = sb.pop_front();
            chk({tag, " quotient"}, quotient, e.q);
            chk({tag, " remainder"}, remainder, e.r);
            chk({tag, " div_by_zero"}, div_by_zero, e.dz);
            if (!e.dz) begin
                chk({tag, " invariant"}, 32'(quotient) * 32'(e.dv) + 32'(remainder), 32'(e.dd));
                chk({tag, " rem_lt_div"}, remainder < e.dv, 1'b1);
            end
        end
    endtask

    initial begin
        int pairs[256];
        int j;
        int tmp;

        reset_n  = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #1;
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset quotient", quotient, 0);
        chk("reset remainder", remainder, 0);
        chk("reset div_by_zero", div_by_zero, 1'b0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("idle busy", busy, 1'b0);
        chk("idle done", done, 1'b0);

        issue(4'd13, 4'd3);
        finish_op("13/3", N + 1, 0);
        @(negedge clock);
        chk("done one pulse", done, 1'b0);

        issue(4'd15, 4'd1);
        finish_op("15/1", N + 1, 0);
        issue(4'd3, 4'd9);
        finish_op("3/9", N + 1, 0);

        @(negedge clock);
        issue(4'd7, 4'd0);
        finish_op("7/0", 1, 0);
        @(negedge clock);

        issue(4'd13, 4'd3);
        finish_op("13/3 ignore_busy_start", N + 1, 2);

        @(negedge clock);
        issue(4'd13, 4'd3);
        finish_op("13/3 before b2b", N + 1, 0);
        issue(4'd6, 4'd2);
        finish_op("6/2 back_to_back", N + 1, 0);

        @(negedge clock);
        issue(4'd13, 4'd3);
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("midrun reset busy", busy, 1'b0);
        chk("midrun reset done", done, 1'b0);
        chk("midrun reset quotient", quotient, 0);
        chk("midrun reset remainder", remainder, 0);
        chk("midrun reset div_by_zero", div_by_zero, 1'b0);
        if (sb.size() != 0) void'(sb.pop_front());
        @(negedge clock);
        chk("held reset done", done, 1'b0);
        reset_n = 1'b1;
        @(negedge clock);
        issue(4'd9, 4'd4);
        finish_op("9/4 after reset", N + 1, 0);

        for (int i = 0; i < 256; i++) pairs[i] = i;
        for (int i = 255; i > 0; i--) begin
            j        = int'($urandom_range(i, 0));
            tmp      = pairs[i];
            pairs[i] = pairs[j];
            pairs[j] = tmp;
        end
        for (int i = 0; i < 256; i++) begin
            tmp = pairs[i];
            issue(N'(tmp >> N), N'(tmp));
            finish_op("sweep", (N'(tmp) == 0) ? 1 : N + 1, 0);
        end

        chk("scoreboard drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
